// File: rtl/vip_genlock_phase_compare_pkg.sv
// Shared types and sizing helpers for the genlock phase comparator.
// Holds the lead-tracking state encoding and the default counter widths.
package vip_genlock_phase_compare_pkg;

    localparam int DEF_H_WIDTH = 14;
    localparam int DEF_V_WIDTH = 13;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_LEAD  = 2'd1,
        ST_OUT_LEAD = 2'd2
    } gl_state_t;

    // Smallest width that can hold CONFIRM_COUNT.
    function automatic int confirm_width(input int count);
        return (count < 1) ? 1 : $clog2(count + 1);
    endfunction

endpackage

// File: rtl/vip_genlock_phase_compare_if.sv
// Control, sync-extractor and timing-generator signals of the genlock comparator.
// master drives the inputs (control/sync side); slave is the comparator itself.
interface vip_genlock_phase_compare_if
    import vip_genlock_phase_compare_pkg::*;
#(
    parameter int H_WIDTH = DEF_H_WIDTH,
    parameter int V_WIDTH = DEF_V_WIDTH
);
    logic               enable;
    logic               restart;
    logic [H_WIDTH-1:0] h_total_minus_one;
    logic [H_WIDTH-1:0] tolerance;
    logic               sof_in;
    logic               sof_in_locked;
    logic               sof_out;
    logic               sof_out_locked;
    logic               sync_lines;
    logic               sync_samples;
    logic               remove_repeatn;
    logic [H_WIDTH-1:0] sync_h_reset;
    logic [V_WIDTH-1:0] sync_v_reset;
    logic               genlocked;
    logic               meas_valid;

    modport master (
        output enable, restart, h_total_minus_one, tolerance,
        output sof_in, sof_in_locked, sof_out, sof_out_locked,
        input  sync_lines, sync_samples, remove_repeatn,
        input  sync_h_reset, sync_v_reset, genlocked, meas_valid
    );

    modport slave (
        input  enable, restart, h_total_minus_one, tolerance,
        input  sof_in, sof_in_locked, sof_out, sof_out_locked,
        output sync_lines, sync_samples, remove_repeatn,
        output sync_h_reset, sync_v_reset, genlocked, meas_valid
    );

endinterface

// File: rtl/vip_genlock_frame_counter.sv
// Sample/line counter measuring the time elapsed since the last start-of-frame edge.
// Wraps samples at h_total_minus_one and saturates the line count.
module vip_genlock_frame_counter
    import vip_genlock_phase_compare_pkg::*;
#(
    parameter int H_WIDTH = DEF_H_WIDTH,
    parameter int V_WIDTH = DEF_V_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclr,
    input  logic               sof_edge,
    input  logic [H_WIDTH-1:0] h_total_minus_one,
    output logic [H_WIDTH-1:0] h_count,
    output logic [V_WIDTH-1:0] v_count
);

    logic [H_WIDTH-1:0] h_reg;
    logic [V_WIDTH-1:0] v_reg;

    // The edge cycle itself is sample 0, so the count restarts one step in.
    always_ff @(posedge clk) begin
        if (rst || sclr) begin
            h_reg <= '0;
            v_reg <= '0;
        end else if (sof_edge) begin
            if (h_total_minus_one == '0) begin
                h_reg <= '0;
                v_reg <= V_WIDTH'(1);
            end else begin
                h_reg <= H_WIDTH'(1);
                v_reg <= '0;
            end
        end else if (h_reg >= h_total_minus_one) begin
            h_reg <= '0;
            if (v_reg != '1) begin
                v_reg <= v_reg + V_WIDTH'(1);
            end
        end else begin
            h_reg <= h_reg + H_WIDTH'(1);
        end
    end

    assign h_count = h_reg;
    assign v_count = v_reg;

endmodule

// File: rtl/vip_genlock_phase_compare.sv
// Genlock phase comparator: measures CVI/CVO start-of-frame offsets in both directions,
// confirms them over repeated frames and drives the timing generator's corrections.
module vip_genlock_phase_compare
    import vip_genlock_phase_compare_pkg::*;
#(
    parameter int H_WIDTH       = DEF_H_WIDTH,
    parameter int V_WIDTH       = DEF_V_WIDTH,
    parameter int CONFIRM_COUNT = 2,
    parameter int OUT_PIPE      = 2
) (
    input logic                        clk,
    input logic                        rst,
    vip_genlock_phase_compare_if.slave bus
);

    localparam int CW = confirm_width(CONFIRM_COUNT);
    localparam int DW = H_WIDTH + V_WIDTH + 5;

    logic               sof_in_q;
    logic               sof_out_q;
    logic               in_edge;
    logic               out_edge;
    logic               active;
    logic               sclr;
    gl_state_t          state_reg;
    gl_state_t          state_next;
    logic [1:0]         cap_dir;
    logic               cap_both;
    logic [H_WIDTH-1:0] h_count;
    logic [V_WIDTH-1:0] v_count;
    logic [H_WIDTH-1:0] cap_h;
    logic [V_WIDTH-1:0] cap_v;
    logic [H_WIDTH-1:0] meas_h_reg [2];
    logic [V_WIDTH-1:0] meas_v_reg [2];
    logic [CW-1:0]      cnt_reg [2];
    logic               valid;
    logic               rm_lines;
    logic [V_WIDTH-1:0] v_next;
    logic [H_WIDTH-1:0] h_next;
    logic               dir_next;
    logic               lines_next;
    logic               samples_next;
    logic               locked_next;
    logic [H_WIDTH-1:0] h_reset_next;
    logic [V_WIDTH-1:0] v_reset_next;
    logic [DW-1:0]      decision_next;
    logic [DW-1:0]      pipe_reg [0:OUT_PIPE];

    always_ff @(posedge clk) begin
        if (rst) begin
            sof_in_q  <= 1'b0;
            sof_out_q <= 1'b0;
        end else begin
            sof_in_q  <= bus.sof_in;
            sof_out_q <= bus.sof_out;
        end
    end

    assign in_edge  = bus.sof_in & ~sof_in_q;
    assign out_edge = bus.sof_out & ~sof_out_q;
    assign active   = bus.enable & bus.sof_in_locked & bus.sof_out_locked;
    assign sclr     = ~active | bus.restart;

    vip_genlock_frame_counter #(
        .H_WIDTH (H_WIDTH),
        .V_WIDTH (V_WIDTH)
    ) u_frame_counter (
        .clk               (clk),
        .rst               (rst),
        .sclr              (sclr),
        .sof_edge          (in_edge | out_edge),
        .h_total_minus_one (bus.h_total_minus_one),
        .h_count           (h_count),
        .v_count           (v_count)
    );

    always_ff @(posedge clk) begin
        if (rst || sclr) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // cap_dir[0] captures the remove offset, cap_dir[1] the repeat offset.
    always_comb begin
        state_next = state_reg;
        cap_dir    = 2'b00;
        cap_both   = 1'b0;
        if (in_edge && out_edge) begin
            state_next = ST_IDLE;
            cap_both   = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_edge) begin
                        state_next = ST_IN_LEAD;
                    end else if (out_edge) begin
                        state_next = ST_OUT_LEAD;
                    end
                end
                ST_IN_LEAD: begin
                    if (out_edge) begin
                        state_next = ST_OUT_LEAD;
                        cap_dir[0] = 1'b1;
                    end
                end
                ST_OUT_LEAD: begin
                    if (in_edge) begin
                        state_next = ST_IN_LEAD;
                        cap_dir[1] = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign cap_h = cap_both ? '0 : h_count;
    assign cap_v = cap_both ? '0 : v_count;

    for (genvar gi = 0; gi < 2; gi++) begin : gen_dir
        always_ff @(posedge clk) begin
            if (rst || sclr) begin
                meas_h_reg[gi] <= '0;
                meas_v_reg[gi] <= '0;
                cnt_reg[gi]    <= '0;
            end else if (cap_dir[gi] || cap_both) begin
                meas_h_reg[gi] <= cap_h;
                meas_v_reg[gi] <= cap_v;
                if (cap_h == meas_h_reg[gi] && cap_v == meas_v_reg[gi]) begin
                    if (cnt_reg[gi] != '1) begin
                        cnt_reg[gi] <= cnt_reg[gi] + CW'(1);
                    end
                end else begin
                    cnt_reg[gi] <= CW'(1);
                end
            end
        end
    end

    assign valid = (cnt_reg[0] >= CW'(CONFIRM_COUNT)) && (cnt_reg[1] >= CW'(CONFIRM_COUNT));

    // Correct towards whichever direction needs fewer lines; direction is reported even unconfirmed.
    always_comb begin
        rm_lines     = meas_v_reg[0] < meas_v_reg[1];
        v_next       = rm_lines ? meas_v_reg[0] : meas_v_reg[1];
        h_next       = rm_lines ? meas_h_reg[0] : meas_h_reg[1];
        dir_next     = (v_next != '0) ? rm_lines : (meas_h_reg[0] < meas_h_reg[1]);
        lines_next   = 1'b0;
        samples_next = 1'b0;
        locked_next  = 1'b0;
        h_reset_next = '0;
        v_reset_next = '0;
        if (valid) begin
            if (v_next != '0) begin
                lines_next   = 1'b1;
                samples_next = 1'b1;
                h_reset_next = h_next;
                v_reset_next = v_next;
            end else if (h_next > bus.tolerance) begin
                samples_next = 1'b1;
                h_reset_next = h_next;
            end else begin
                locked_next = 1'b1;
            end
        end
        decision_next = {lines_next, samples_next, dir_next, locked_next, valid,
                         h_reset_next, v_reset_next};
    end

    always_ff @(posedge clk) begin
        if (rst || sclr) begin
            pipe_reg[0] <= '0;
        end else begin
            pipe_reg[0] <= decision_next;
        end
    end

    for (genvar gi = 1; gi <= OUT_PIPE; gi++) begin : gen_pipe
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_reg[gi] <= '0;
            end else begin
                pipe_reg[gi] <= pipe_reg[gi-1];
            end
        end
    end

    assign {bus.sync_lines, bus.sync_samples, bus.remove_repeatn, bus.genlocked,
            bus.meas_valid, bus.sync_h_reset, bus.sync_v_reset} = pipe_reg[OUT_PIPE];

endmodule

// File: tb/tb_vip_genlock_phase_compare.sv
// Scoreboard bench for the genlock phase comparator: frames of 1000 cycles, 100-sample lines,
// expected corrections derived from the programmed CVI/CVO offsets.
module tb_vip_genlock_phase_compare;

    typedef struct {
        int         due;
        int         id;
        bit         chk_dir;
        logic       sl;
        logic       ss;
        logic       dir;
        logic       gl;
        logic       mv;
        logic [13:0] hr;
        logic [12:0] vr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   mon_i;
    exp_t sb[$];
    exp_t e;

    vip_genlock_phase_compare_if #(.H_WIDTH(14), .V_WIDTH(13)) bus ();

    vip_genlock_phase_compare #(
        .H_WIDTH       (14),
        .V_WIDTH       (13),
        .CONFIRM_COUNT (2),
        .OUT_PIPE      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected decision for remove/repeat offsets given in cycles (100 samples per line).
    function automatic exp_t model(input int id, input int rm_c, input int rp_c,
                                   input int tol, input bit valid);
        exp_t r;
        int vrm, hrm, vrp, hrp, vn, hn;
        bit rml;
        vrm = rm_c / 100; hrm = rm_c % 100;
        vrp = rp_c / 100; hrp = rp_c % 100;
        rml = vrm < vrp;
        vn  = rml ? vrm : vrp;
        hn  = rml ? hrm : hrp;
        r.due = 0; r.id = id; r.chk_dir = valid;
        r.sl = 0; r.ss = 0; r.gl = 0; r.mv = valid; r.hr = '0; r.vr = '0;
        r.dir = (vn > 0) ? rml : (hrm < hrp);
        if (valid) begin
            if (vn > 0) begin
                r.sl = 1; r.ss = 1; r.hr = 14'(hn); r.vr = 13'(vn);
            end else if (hn > tol) begin
                r.ss = 1; r.hr = 14'(hn);
            end else begin
                r.gl = 1;
            end
        end
        return r;
    endfunction

    function automatic exp_t zeros(input int id);
        exp_t r;
        r = model(id, 0, 0, 0, 1'b0);
        r.chk_dir = 1'b1;
        return r;
    endfunction

    task automatic compare(input exp_t x);
        chk($sformatf("s%0d_sync_lines@%0d", x.id, cyc), 32'(bus.sync_lines), 32'(x.sl));
        chk($sformatf("s%0d_sync_samples@%0d", x.id, cyc), 32'(bus.sync_samples), 32'(x.ss));
        chk($sformatf("s%0d_sync_h_reset@%0d", x.id, cyc), 32'(bus.sync_h_reset), 32'(x.hr));
        chk($sformatf("s%0d_sync_v_reset@%0d", x.id, cyc), 32'(bus.sync_v_reset), 32'(x.vr));
        chk($sformatf("s%0d_genlocked@%0d", x.id, cyc), 32'(bus.genlocked), 32'(x.gl));
        chk($sformatf("s%0d_meas_valid@%0d", x.id, cyc), 32'(bus.meas_valid), 32'(x.mv));
        if (x.chk_dir)
            chk($sformatf("s%0d_remove_repeatn@%0d", x.id, cyc), 32'(bus.remove_repeatn), 32'(x.dir));
    endtask

    always @(negedge clk) begin
        mon_i = 0;
        while (mon_i < sb.size()) begin
            if (sb[mon_i].due == cyc) begin
                compare(sb[mon_i]);
                sb.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input exp_t x, input int delay);
        exp_t y;
        y = x;
        y.due = cyc + delay;
        sb.push_back(y);
    endtask

    // clr_kind: 0 none, 1 drop sof_out_locked, 2 restart, 3 rst -- one cycle at t=500 of clr_frame.
    task automatic run_scen(input int id, input int in_off, input int out_off, input bit jitter,
                            input int tol, input int nframes, input int clr_kind, input int clr_frame);
        int  k, vt, oo, d, rm_c, rp_c, t_cap;
        bit  clr_now;
        bus.tolerance = 14'(tol);
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        repeat (9) tick();
        k  = -1;
        vt = (in_off == out_off) ? 1 : 2;
        for (int f = 0; f < nframes; f++) begin
            k++;
            oo = out_off + (jitter ? (f % 2) : 0);
            d  = oo - in_off;
            if (d > 0) begin
                rm_c = d; rp_c = 1000 - d;
            end else if (d < 0) begin
                rp_c = -d; rm_c = 1000 + d;
            end else begin
                rm_c = 0; rp_c = 0;
            end
            t_cap = (in_off < oo) ? in_off : oo;
            for (int t = 0; t < 1000; t++) begin
                clr_now = (clr_kind != 0) && (f == clr_frame) && (t == 500);
                bus.sof_in         = (t >= in_off) && (t < in_off + 20);
                bus.sof_out        = (t >= oo) && (t < oo + 20);
                bus.sof_out_locked = !(clr_now && clr_kind == 1);
                bus.restart        = clr_now && clr_kind == 2;
                rst                = clr_now && clr_kind == 3;
                if (t == 0)
                    push(model(id, rm_c, rp_c, tol,
                               (k >= vt) && !jitter && !(clr_kind != 0 && f == clr_frame)), 990);
                if (t == t_cap && k == vt && !jitter) begin
                    push(model(id, 0, 0, 0, 1'b0), 3);
                    push(model(id, rm_c, rp_c, tol, 1'b1), 4);
                end
                if (clr_now) begin
                    if (clr_kind != 3) begin
                        push(model(id, rm_c, rp_c, tol, (k >= vt) && !jitter), 2);
                        push(zeros(id), 3);
                    end else begin
                        push(zeros(id), 1);
                    end
                    k = -1;
                end
                tick();
            end
        end
        bus.sof_in = 1'b0;
        bus.sof_out = 1'b0;
        bus.sof_out_locked = 1'b1;
        bus.restart = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b1;
        bus.restart = 1'b0;
        bus.h_total_minus_one = 14'd99;
        bus.tolerance = 14'd0;
        bus.sof_in = 1'b0;
        bus.sof_in_locked = 1'b1;
        bus.sof_out = 1'b0;
        bus.sof_out_locked = 1'b1;
        repeat (3) tick();
        push(zeros(0), 0);
        rst = 1'b0;
        push(zeros(0), 5);
        repeat (8) tick();

        run_scen(1, 0, 250, 1'b0, 0, 3, 0, 0);   // input leads by 250
        run_scen(2, 30, 0, 1'b0, 0, 3, 0, 0);    // output leads by 30
        run_scen(3, 0, 3, 1'b0, 4, 3, 0, 0);     // within tolerance
        run_scen(4, 0, 0, 1'b0, 0, 2, 0, 0);     // coincident edges
        run_scen(5, 0, 250, 1'b1, 0, 4, 0, 0);   // jittering offset
        run_scen(6, 0, 3, 1'b0, 4, 7, 1, 3);     // lock drop
        run_scen(7, 0, 3, 1'b0, 4, 7, 2, 3);     // restart
        run_scen(8, 0, 3, 1'b0, 4, 7, 3, 3);     // rst

        repeat (5) tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
